// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Purpose  : Sequencing controller for the CPU multiply/divide resources.
//             Accepts MUL/MULT/MULTU/DIV/DIVU/MTHI/MTLO from execute, drives
//             the shared pipelined multiplier and the iterative divider, owns
//             the HI/LO architectural registers and stalls the pipeline while
//             an operation is in flight.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1   clock, all state on rising edge
//    rst_n         in   1   asynchronous active-low reset (shared w/ divider)
//    start_i       in   1   op request, sampled only in IDLE
//    op_i          in   3   000 MUL 001 MULT 010 MULTU 011 DIV 100 DIVU
//                           101 MTHI 110 MTLO 111 no-op
//    rs_val_i      in  32   operand A (dividend/multiplicand/MTHI-MTLO data)
//    rt_val_i      in  32   operand B (divisor/multiplier)
//    busy_o        out  1   stall request, high whenever state != IDLE
//    done_o        out  1   one-cycle completion pulse
//    gpr_result_o  out 32   MUL low word
//    hi_o / lo_o   out 32   HI / LO registers
//    mul_a_o/_b_o  out 32   multiplier operands (held from latch)
//    mul_signed_o  out  1   1 = signed product
//    mul_p_i       in  64   multiplier product {hi,lo}
//    div_start_o   out  1   one-cycle divider launch pulse
//    div_signed_o  out  1   1 = signed divide
//    div_a_o/_b_o  out 32   dividend / divisor (held from latch)
//    div_done_i    in   1   divider completion pulse
//    div_q_i/_r_i  in  32   quotient / remainder
// ============================================================================
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] gpr_result_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_signed_o,
  input  logic [63:0] mul_p_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  input  logic        div_done_i,
  input  logic [31:0] div_q_i,
  input  logic [31:0] div_r_i
);

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  localparam int         CNT_W    = 4;
  // Countdown starts at MUL_LAT-1 so capture lands MUL_LAT edges after accept.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MUL_WAIT  = 2'd1,
    S_DIV_START = 2'd2,
    S_DIV_WAIT  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q,    op_d;
  logic [31:0]        a_q,     a_d;
  logic [31:0]        b_q,     b_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [31:0]        hi_q,    hi_d;
  logic [31:0]        lo_q,    lo_d;
  logic [31:0]        gpr_q,   gpr_d;
  logic               done_q,  done_d;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      // Latched op resets to no-op so the signedness decodes read 0.
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      gpr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      gpr_q   <= gpr_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    gpr_d   = gpr_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d = op_i;
          a_d  = rs_val_i;
          b_d  = rt_val_i;
          case (op_i)
            OP_MUL, OP_MULT, OP_MULTU: begin
              state_d = S_MUL_WAIT;
              cnt_d   = CNT_INIT;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero never launches the divider; HI/LO keep their
              // values and the op retires immediately.
              if (rt_val_i == 32'd0) begin
                done_d = 1'b1;
              end else begin
                state_d = S_DIV_START;
              end
            end
            OP_MTHI: begin
              hi_d   = rs_val_i;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = rs_val_i;
              done_d = 1'b1;
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end
      end

      S_MUL_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          // MUL only targets the GPR; MULT/MULTU write the full product.
          if (op_q == OP_MUL) begin
            gpr_d = mul_p_i[31:0];
          end else begin
            hi_d = mul_p_i[63:32];
            lo_d = mul_p_i[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DIV_START: begin
        state_d = S_DIV_WAIT;
      end

      S_DIV_WAIT: begin
        if (div_done_i) begin
          lo_d    = div_q_i;
          hi_d    = div_r_i;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign gpr_result_o = gpr_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;

  // Both units see the same latched operands; only the launch/capture differ.
  assign mul_a_o      = a_q;
  assign mul_b_o      = b_q;
  assign div_a_o      = a_q;
  assign div_b_o      = b_q;

  assign mul_signed_o = (op_q == OP_MUL) || (op_q == OP_MULT);
  assign div_signed_o = (op_q == OP_DIV);
  assign div_start_o  = (state_q == S_DIV_START);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_ctrl
//  Purpose  : Self-checking bench for muldiv_ctrl with stub multiplier and
//             stub divider and an arithmetic reference model of HI/LO/GPR.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;
  localparam int DIV_BUSY = 6;  // DIV_START cycle + 5-cycle stub divider

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b111;
  logic [31:0] rs = '0, rt = '0;
  logic        busy, done, mul_signed, div_start, div_signed, div_done;
  logic [31:0] gpr, hi, lo, mul_a, mul_b, div_a, div_b, div_q, div_r;
  logic [63:0] mul_p;

  int nvec = 0;
  int nerr = 0;

  // model state
  logic [31:0] hi_m = '0, lo_m = '0, gpr_m = '0;

  // results of last wait_done
  int  r_busy_n, r_dstarts;
  bit  r_timeout, r_busy_at_done, r_ms, r_ds;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op),
    .rs_val_i(rs), .rt_val_i(rt), .busy_o(busy), .done_o(done),
    .gpr_result_o(gpr), .hi_o(hi), .lo_o(lo), .mul_a_o(mul_a),
    .mul_b_o(mul_b), .mul_signed_o(mul_signed), .mul_p_i(mul_p),
    .div_start_o(div_start), .div_signed_o(div_signed), .div_a_o(div_a),
    .div_b_o(div_b), .div_done_i(div_done), .div_q_i(div_q), .div_r_i(div_r)
  );

  // ---------------- stub multiplier: one register stage (MUL_LAT=2) -------
  logic [63:0] prod, mul_p_q;
  always_comb begin
    prod = '0;
    if (mul_signed) prod = 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
    else            prod = 64'(mul_a) * 64'(mul_b);
  end
  always_ff @(posedge clk) mul_p_q <= prod;
  assign mul_p = mul_p_q;

  // ---------------- stub divider: div_done 5 cycles after div_start -------
  logic [2:0] dcnt;
  logic       stray = 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            dcnt <= '0;
    else if (div_start)    dcnt <= 3'd5;
    else if (dcnt != 3'd0) dcnt <= dcnt - 3'd1;
  end
  assign div_done = (dcnt == 3'd1) | stray;
  always_comb begin
    div_q = '0;
    div_r = '0;
    if (div_b != 32'd0) begin
      if (div_signed) begin
        div_q = 32'($signed(div_a) / $signed(div_b));
        div_r = 32'($signed(div_a) % $signed(div_b));
      end else begin
        div_q = div_a / div_b;
        div_r = div_a % div_b;
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 7)); rs = $urandom; rt = $urandom;
  endtask

  task automatic wait_done();
    r_busy_n = 0; r_dstarts = 0; r_timeout = 1'b1; r_busy_at_done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 0) begin r_ms = mul_signed; r_ds = div_signed; end
      if (done) begin r_timeout = 1'b0; r_busy_at_done = busy; break; end
      if (busy) r_busy_n++;
      if (div_start) r_dstarts++;
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit b2b);
    if (!b2b) @(negedge clk);
    issue(o, a, b);
    wait_done();
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    nvec++; if (busy !== 1'b0)   begin nerr++; $display("FAIL reset_busy got %b exp 0", busy); end
    nvec++; if (done !== 1'b0)   begin nerr++; $display("FAIL reset_done got %b exp 0", done); end
    nvec++; if (hi !== 32'd0)    begin nerr++; $display("FAIL reset_hi got %h exp 0", hi); end
    nvec++; if (lo !== 32'd0)    begin nerr++; $display("FAIL reset_lo got %h exp 0", lo); end
    nvec++; if (gpr !== 32'd0)   begin nerr++; $display("FAIL reset_gpr got %h exp 0", gpr); end
    nvec++; if ({mul_a, mul_b, div_a, div_b} !== 128'd0)
      begin nerr++; $display("FAIL reset_operands got %h exp 0", {mul_a, mul_b, div_a, div_b}); end
    nvec++; if ({div_start, mul_signed, div_signed} !== 3'b000)
      begin nerr++; $display("FAIL reset_ctl got %b exp 000", {div_start, mul_signed, div_signed}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    run_op(3'b001, 32'hFFFF_FFFD, 32'd5, 1'b0);
    nvec++; if (r_timeout)      begin nerr++; $display("FAIL mult_timeout got timeout exp done"); end
    nvec++; if (r_busy_n != MUL_LAT) begin nerr++; $display("FAIL mult_busy_cycles got %0d exp %0d", r_busy_n, MUL_LAT); end
    nvec++; if (r_ms !== 1'b1)  begin nerr++; $display("FAIL mult_signed got %b exp 1", r_ms); end
    nvec++; if (r_busy_at_done !== 1'b0) begin nerr++; $display("FAIL mult_busy_at_done got 1 exp 0"); end
    nvec++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
    nvec++; if (lo !== 32'hFFFF_FFF1) begin nerr++; $display("FAIL mult_lo got %h exp fffffff1", lo); end
    hi_m = 32'hFFFF_FFFF; lo_m = 32'hFFFF_FFF1;
    @(negedge clk);
    nvec++; if (done !== 1'b0)  begin nerr++; $display("FAIL mult_done_width got %b exp 0", done); end
  endtask

  task automatic test_multu_mul_b2b();
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 1'b0);
    nvec++; if (r_ms !== 1'b0)  begin nerr++; $display("FAIL multu_signed got %b exp 0", r_ms); end
    nvec++; if ({hi, lo} !== 64'h1_FFFF_FFFE) begin nerr++; $display("FAIL multu_hilo got %h exp 1fffffffe", {hi, lo}); end
    run_op(3'b000, 32'd7, 32'd6, 1'b1);  // issued in the done cycle
    nvec++; if (r_timeout || r_busy_n != MUL_LAT)
      begin nerr++; $display("FAIL mul_b2b_busy got %0d/%b exp %0d", r_busy_n, r_timeout, MUL_LAT); end
    nvec++; if (gpr !== 32'd42) begin nerr++; $display("FAIL mul_gpr got %0d exp 42", gpr); end
    nvec++; if ({hi, lo} !== 64'h1_FFFF_FFFE) begin nerr++; $display("FAIL mul_hilo_kept got %h exp 1fffffffe", {hi, lo}); end
    // MTLO in the done cycle after a MULTU-style write
    run_op(3'b110, 32'h1234_5678, 32'd0, 1'b1);
    nvec++; if ({hi, lo} !== 64'h1_1234_5678) begin nerr++; $display("FAIL mtlo_b2b got %h exp 112345678", {hi, lo}); end
    hi_m = 32'd1; lo_m = 32'h1234_5678; gpr_m = 32'd42;
  endtask

  task automatic test_div();
    run_op(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0);
    nvec++; if (r_timeout)      begin nerr++; $display("FAIL div_timeout got timeout exp done"); end
    nvec++; if (r_dstarts != 1) begin nerr++; $display("FAIL div_start_cycles got %0d exp 1", r_dstarts); end
    nvec++; if (r_ds !== 1'b1)  begin nerr++; $display("FAIL div_signed got %b exp 1", r_ds); end
    nvec++; if (r_busy_n != DIV_BUSY) begin nerr++; $display("FAIL div_busy_cycles got %0d exp %0d", r_busy_n, DIV_BUSY); end
    nvec++; if (lo !== 32'hFFFF_FFFD) begin nerr++; $display("FAIL div_lo got %h exp fffffffd", lo); end
    nvec++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL div_hi got %h exp ffffffff", hi); end
    nvec++; if (r_busy_at_done !== 1'b0) begin nerr++; $display("FAIL div_busy_after got 1 exp 0"); end
    hi_m = 32'hFFFF_FFFF; lo_m = 32'hFFFF_FFFD;
  endtask

  task automatic test_div_zero();
    run_op(3'b101, 32'h11, 32'd0, 1'b0);
    run_op(3'b110, 32'h22, 32'd0, 1'b1);
    run_op(3'b100, 32'h99, 32'd0, 1'b0);
    nvec++; if (r_timeout || r_busy_n != 0 || r_dstarts != 0)
      begin nerr++; $display("FAIL divz_noop got busy=%0d starts=%0d to=%b exp 0/0/0", r_busy_n, r_dstarts, r_timeout); end
    nvec++; if ({hi, lo} !== {32'h11, 32'h22}) begin nerr++; $display("FAIL divz_hilo got %h exp 1100000022", {hi, lo}); end
    hi_m = 32'h11; lo_m = 32'h22;
  endtask

  task automatic test_mthi_mtlo_stray();
    run_op(3'b101, 32'hA5A5_A5A5, 32'd0, 1'b0);
    nvec++; if (r_timeout || r_busy_n != 0) begin nerr++; $display("FAIL mthi_busy got %0d exp 0", r_busy_n); end
    run_op(3'b110, 32'h5A5A_5A5A, 32'd0, 1'b0);
    nvec++; if ({hi, lo} !== 64'hA5A5A5A5_5A5A5A5A) begin nerr++; $display("FAIL mthi_mtlo got %h exp a5a5a5a55a5a5a5a", {hi, lo}); end
    @(negedge clk); stray = 1'b1; @(negedge clk); stray = 1'b0; @(negedge clk);
    nvec++; if ({hi, lo, done, busy} !== {64'hA5A5A5A5_5A5A5A5A, 2'b00})
      begin nerr++; $display("FAIL stray_div_done got %h/%b%b exp unchanged/00", {hi, lo}, done, busy); end
    hi_m = 32'hA5A5_A5A5; lo_m = 32'h5A5A_5A5A;
  endtask

  task automatic test_busy_ignore();
    @(negedge clk);
    issue(3'b011, 32'd100, 32'd7);
    @(negedge clk); @(negedge clk);
    start = 1'b1; op = 3'b101; rs = 32'hDEAD_BEEF;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    nvec++; if (r_timeout) begin nerr++; $display("FAIL ignore_timeout got timeout exp done"); end
    nvec++; if ({hi, lo} !== {32'd2, 32'd14}) begin nerr++; $display("FAIL ignore_hilo got %h exp 000000020000000e", {hi, lo}); end
    @(negedge clk); @(negedge clk);
    nvec++; if ({hi, done, busy} !== {32'd2, 2'b00}) begin nerr++; $display("FAIL ignore_not_queued got %h/%b%b exp 2/00", hi, done, busy); end
    hi_m = 32'd2; lo_m = 32'd14;
  endtask

  task automatic test_reset_mid_div();
    bit saw;
    @(negedge clk);
    issue(3'b100, 32'd1000, 32'd3);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++; if ({busy, done, div_start} !== 3'b000) begin nerr++; $display("FAIL rst_mid_ctl got %b exp 000", {busy, done, div_start}); end
    nvec++; if ({hi, lo, gpr} !== 96'd0) begin nerr++; $display("FAIL rst_mid_regs got %h exp 0", {hi, lo, gpr}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    hi_m = '0; lo_m = '0; gpr_m = '0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      stray = (i == 3);
      if (done || busy) saw = 1'b1;
    end
    stray = 1'b0;
    @(negedge clk);
    nvec++; if (saw || done) begin nerr++; $display("FAIL rst_mid_no_done got 1 exp 0"); end
    nvec++; if ({hi, lo} !== 64'd0) begin nerr++; $display("FAIL rst_mid_late_div_done got %h exp 0", {hi, lo}); end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    int          exp_busy, exp_starts;
    for (int n = 0; n < 60; n++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      if (o == 3'b011 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      exp_busy = 0; exp_starts = 0;
      case (o)
        3'b000: begin gpr_m = a * b; exp_busy = MUL_LAT; end
        3'b001: begin {hi_m, lo_m} = 64'(longint'($signed(a)) * longint'($signed(b))); exp_busy = MUL_LAT; end
        3'b010: begin {hi_m, lo_m} = 64'(a) * 64'(b); exp_busy = MUL_LAT; end
        3'b011: if (b != 0) begin
                  lo_m = 32'($signed(a) / $signed(b)); hi_m = 32'($signed(a) % $signed(b));
                  exp_busy = DIV_BUSY; exp_starts = 1;
                end
        3'b100: if (b != 0) begin
                  lo_m = a / b; hi_m = a % b; exp_busy = DIV_BUSY; exp_starts = 1;
                end
        3'b101: hi_m = a;
        3'b110: lo_m = a;
        default: ;
      endcase
      run_op(o, a, b, bit'($urandom_range(0, 1)));
      nvec++; if (r_timeout) begin nerr++; $display("FAIL rnd%0d_timeout op=%0d got timeout exp done", n, o); end
      nvec++; if (r_busy_n != exp_busy || r_dstarts != exp_starts)
        begin nerr++; $display("FAIL rnd%0d_timing op=%0d got busy=%0d starts=%0d exp %0d/%0d", n, o, r_busy_n, r_dstarts, exp_busy, exp_starts); end
      nvec++; if (hi !== hi_m || lo !== lo_m)
        begin nerr++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got %h_%h exp %h_%h", n, o, a, b, hi, lo, hi_m, lo_m); end
      nvec++; if (gpr !== gpr_m) begin nerr++; $display("FAIL rnd%0d_gpr op=%0d got %h exp %h", n, o, gpr, gpr_m); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_mul_b2b();
    test_div();
    test_div_zero();
    test_mthi_mtlo_stray();
    test_busy_ignore();
    test_reset_mid_div();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller for the CPU's multiply/divide resources.
- Accepts MUL/MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage. Drives the shared pipelined multiplier and the iterative divider, and owns the HI/LO architectural registers.
- Holds busy high to stall the pipeline while an operation is in flight. Returns the MUL low-word result for GPR writeback.

Parameters:
MUL_LAT, 2, cycles from operands presented on mul_a/mul_b to a valid mul_p; legal range 1..15

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  op request, sampled only in IDLE
op  in  3  000 MUL, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 no-op
rs_val  in  32  operand A (dividend / multiplicand / MTHI-MTLO data)
rt_val  in  32  operand B (divisor / multiplier)
busy  out  1  stall request, high whenever state != IDLE
done  out  1  one-cycle completion pulse
gpr_result  out  32  MUL low word, valid while done=1 and op was MUL
hi  out  32  HI register
lo  out  32  LO register
mul_a  out  32  multiplier operand A, held from latch
mul_b  out  32  multiplier operand B, held from latch
mul_signed  out  1  1 = signed product
mul_p  in  64  multiplier product {hi,lo}
div_start  out  1  one-cycle divider launch pulse
div_signed  out  1  1 = signed divide
div_a  out  32  dividend, held from latch
div_b  out  32  divisor, held from latch
div_done  in  1  divider completion pulse, quotient/remainder valid
div_q  in  32  quotient
div_r  in  32  remainder

Behaviour:
- Reset (reset=0, async): state=IDLE.
  - hi, lo, gpr_result, operand latches = 0.
  - busy, done, div_start = 0; mul_signed, div_signed = 0.
- States: IDLE, MUL_WAIT, DIV_START, DIV_WAIT.
- At any edge with start=1 in IDLE, the op is accepted (edge E0). op, rs_val and rt_val are latched into op_r/a_r/b_r.
- Latched operands drive mul_a/div_a and mul_b/div_b continuously.
- mul_signed is 1 for MUL/MULT. div_signed is 1 for DIV.
- MTHI/MTLO:
  - At E0, hi (or lo) <= rs_val.
  - done=1 for the cycle after E0.
  - State stays IDLE; busy never rises.
- no-op (111): done=1 for the cycle after E0, no register change.
- MUL/MULT/MULTU:
  - E0 moves to MUL_WAIT with cnt=MUL_LAT-1.
  - cnt decrements each cycle.
  - At the edge where cnt==0 (E0+MUL_LAT), capture the product:
    - MULT/MULTU: hi<=mul_p[63:32], lo<=mul_p[31:0].
    - MUL: gpr_result<=mul_p[31:0]; hi/lo unchanged.
  - Same edge: state->IDLE, done=1 for one cycle.
- DIV/DIVU:
  - divisor (rt_val)==0 at E0: no divider launch, hi/lo unchanged, done=1 next cycle, state stays IDLE.
  - divisor != 0:
    - E0 -> DIV_START. div_start=1 for exactly that cycle.
    - Next edge -> DIV_WAIT.
    - In DIV_WAIT, at the edge with div_done=1: lo<=div_q, hi<=div_r, state->IDLE, done=1 for one cycle.
  - No timeout.
- busy is a combinational decode of state (busy = state != IDLE). It falls in the same cycle done is high.
- start while busy is ignored. The op is not queued; the pipeline is stalled and must re-present it.
- start in the done cycle (IDLE) is accepted normally, giving back-to-back ops. A MTHI/MTLO issued then sees the just-written hi/lo.
- div_done outside DIV_WAIT is ignored. mul_p is sampled only at the capture edge.
- Reset asserted mid-operation aborts it immediately:
  - all reset values apply, no done pulse.
  - The divider is reset by the same net.
- hi/lo change only at capture edges and MTHI/MTLO acceptance.

Test Plan:
- MULT, rs=0xFFFFFFFD (-3), rt=5, MUL_LAT=2 -> busy high 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done one cycle, mul_signed=1.
- MULTU, rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE. Then MUL with rs=7, rt=6 back-to-back in the done cycle -> gpr_result=42, hi/lo unchanged.
- DIV, rs=0xFFFFFFF9 (-7), rt=2, stub divider pulses div_done 5 cycles after div_start -> div_start exactly one cycle, div_signed=1, lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy low after capture.
- DIVU, rt=0, with hi=0x11, lo=0x22 -> no div_start, busy never rises, done next cycle, hi=0x11, lo=0x22.
- MTHI rs=0xA5A5A5A5, then MTLO rs=0x5A5A5A5A; start pulsed during a pending DIV -> hi/lo set; start ignored while busy; stray div_done in IDLE has no effect.
- Reset driven low 2 cycles into a DIV_WAIT -> immediately state IDLE, busy=0, hi=lo=0, no done. A later div_done pulse is ignored.
